// File: rtl/trk_result_tx_if.sv
// Byte handshake between the result packetizer (master) and the UART TX core (slave).
interface trk_result_tx_if;
  logic [7:0] tx_byte;
  logic       tx_byte_vld;
  logic       tx_byte_rdy;

  modport master (output tx_byte, output tx_byte_vld, input tx_byte_rdy);
  modport slave  (input tx_byte, input tx_byte_vld, output tx_byte_rdy);
endinterface

// File: rtl/trk_result_tx.sv
// Tracking-result packetizer: header, big-endian x/y/w/h (+ confidence), checksum, with a
// one-deep pending buffer. Optional confidence word enabled by macro TRK_TX_CSF_EN.
module trk_result_tx #(
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [7:0]  HDR0       = 8'hAA,
  parameter logic [7:0]  HDR1       = 8'h55
) (
  input  logic                   iclk,
  input  logic                   s_rst,
  input  logic                   tx_start,
  input  logic [15:0]            result_x,
  input  logic [15:0]            result_y,
  input  logic [15:0]            result_w,
  input  logic [15:0]            result_h,
  input  logic [31:0]            result_csf,
  trk_result_tx_if.master        tx,
  output logic                   busy,
  output logic                   pkt_done,
  output logic [7:0]             drop_cnt
);

`ifdef TRK_TX_CSF_EN
  localparam int unsigned N_BYTES = 15;
`else
  localparam int unsigned N_BYTES = 11;
`endif
  localparam logic [3:0]  LAST_IDX = 4'(N_BYTES - 1);
  localparam logic [15:0] GAP_INIT = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_sh_x, r_sh_y, r_sh_w, r_sh_h;
  logic [15:0] r_pd_x, r_pd_y, r_pd_w, r_pd_h;
  logic        r_pend_full;
  logic [3:0]  r_idx;
  logic [7:0]  r_csum;
  logic [7:0]  r_tx_byte;
  logic        r_tx_vld;
  logic        r_pkt_done;
  logic [7:0]  r_drop;
  logic [15:0] r_gap_cnt;

  logic        w_xfer, w_last_xfer, w_load_shadow, w_from_pend, w_pend_capture;
  logic [3:0]  w_idx_nxt;
  logic [7:0]  w_csum_acc, w_nxt_byte;

`ifdef TRK_TX_CSF_EN
  logic [31:0] r_sh_csf, r_pd_csf;
`else
  logic        w_unused_csf;
  assign w_unused_csf = ^result_csf;
`endif

  assign tx.tx_byte     = r_tx_byte;
  assign tx.tx_byte_vld = r_tx_vld;
  assign busy           = (r_state != S_IDLE) || r_pend_full;
  assign pkt_done       = r_pkt_done;
  assign drop_cnt       = r_drop;

  assign w_xfer         = r_tx_vld && tx.tx_byte_rdy;
  assign w_idx_nxt      = r_idx + 4'd1;
  // The byte being accepted is r_tx_byte itself, so the sum folds in the registered copy.
  assign w_csum_acc     = (r_idx >= 4'd2) ? r_csum + r_tx_byte : r_csum;
  assign w_pend_capture = tx_start && ((r_state != S_IDLE) || r_pend_full);

  always_comb begin
    w_nxt_byte = w_csum_acc;
    case (w_idx_nxt)
      4'd1:    w_nxt_byte = HDR1;
      4'd2:    w_nxt_byte = r_sh_x[15:8];
      4'd3:    w_nxt_byte = r_sh_x[7:0];
      4'd4:    w_nxt_byte = r_sh_y[15:8];
      4'd5:    w_nxt_byte = r_sh_y[7:0];
      4'd6:    w_nxt_byte = r_sh_w[15:8];
      4'd7:    w_nxt_byte = r_sh_w[7:0];
      4'd8:    w_nxt_byte = r_sh_h[15:8];
      4'd9:    w_nxt_byte = r_sh_h[7:0];
`ifdef TRK_TX_CSF_EN
      4'd10:   w_nxt_byte = r_sh_csf[31:24];
      4'd11:   w_nxt_byte = r_sh_csf[23:16];
      4'd12:   w_nxt_byte = r_sh_csf[15:8];
      4'd13:   w_nxt_byte = r_sh_csf[7:0];
`endif
      default: w_nxt_byte = w_csum_acc;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_shadow = 1'b0;
    w_from_pend   = 1'b0;
    w_last_xfer   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_full) begin
          w_load_shadow = 1'b1;
          w_from_pend   = 1'b1;
          w_state_nxt   = S_SEND;
        end else if (tx_start) begin
          w_load_shadow = 1'b1;
          w_state_nxt   = S_SEND;
        end
      end
      S_SEND: begin
        if (w_xfer && (r_idx == LAST_IDX)) begin
          w_last_xfer = 1'b1;
          w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (s_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge iclk) begin
    if (s_rst) begin
      r_sh_x <= '0; r_sh_y <= '0; r_sh_w <= '0; r_sh_h <= '0;
      r_pd_x <= '0; r_pd_y <= '0; r_pd_w <= '0; r_pd_h <= '0;
`ifdef TRK_TX_CSF_EN
      r_sh_csf <= '0;
      r_pd_csf <= '0;
`endif
      r_pend_full <= 1'b0;
      r_drop      <= '0;
    end else begin
      if (w_load_shadow) begin
        r_sh_x <= w_from_pend ? r_pd_x : result_x;
        r_sh_y <= w_from_pend ? r_pd_y : result_y;
        r_sh_w <= w_from_pend ? r_pd_w : result_w;
        r_sh_h <= w_from_pend ? r_pd_h : result_h;
`ifdef TRK_TX_CSF_EN
        r_sh_csf <= w_from_pend ? r_pd_csf : result_csf;
`endif
      end
      if (w_pend_capture) begin
        r_pd_x <= result_x; r_pd_y <= result_y;
        r_pd_w <= result_w; r_pd_h <= result_h;
`ifdef TRK_TX_CSF_EN
        r_pd_csf <= result_csf;
`endif
      end
      // Simultaneous consume and capture leaves the buffer full with the new entry.
      if (w_pend_capture)   r_pend_full <= 1'b1;
      else if (w_from_pend) r_pend_full <= 1'b0;
      if (tx_start && (r_state != S_IDLE) && r_pend_full && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;
    end
  end

  always_ff @(posedge iclk) begin
    if (s_rst) begin
      r_idx      <= '0;
      r_csum     <= '0;
      r_tx_byte  <= '0;
      r_tx_vld   <= 1'b0;
      r_pkt_done <= 1'b0;
      r_gap_cnt  <= '0;
    end else begin
      r_pkt_done <= w_last_xfer;
      if (w_load_shadow) begin
        r_idx     <= '0;
        r_csum    <= '0;
        r_tx_byte <= HDR0;
        r_tx_vld  <= 1'b1;
      end else if (w_last_xfer) begin
        r_tx_vld  <= 1'b0;
      end else if (w_xfer) begin
        r_idx     <= w_idx_nxt;
        r_csum    <= w_csum_acc;
        r_tx_byte <= w_nxt_byte;
      end
      if (w_last_xfer)
        r_gap_cnt <= GAP_INIT;
      else if ((r_state == S_GAP) && (r_gap_cnt != '0))
        r_gap_cnt <= r_gap_cnt - 16'd1;
    end
  end

endmodule
